axi4_rd_arbiter: RTL and testbench

Shares the single core AXI4 read master port of `riscv_top` between N internal requesters, e.g. instruction fetch and data load. Each accepted read burst owns the port from AR handshake through RLAST. Only one transaction is outstanding at a time, so no ID remapping is needed. Sits between the core's fetch/LSU read ports and the `AXI_AR_M`/`AXI_R_S` channels checked by `axi4_assert`.

---
 rtl/axi4_pkg.sv | 24 ++
 rtl/axi4_rr_pick.sv | 47 ++++
 rtl/axi4_rd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 read-arbiter types and constants.
// Optional build macro: AXI4_RD_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package axi4_pkg;

    // Arbiter FSM: wait for a request, present AR, stream R beats.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Next round-robin start position after requester idx was served.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi4_rr_pick.sv
// Combinational N-way rotating-priority picker.
// The search starts at ptr and wraps; the first requesting index wins.
// With AXI4_RD_ARB_FIXED_PRIO_EN defined the start is always index 0.
module axi4_rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr_eff;
    logic [IW-1:0] rot_idx [N];

`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign ptr_eff    = '0;
`else
    assign ptr_eff = ptr;
`endif

    // rot_idx[k] is the requester examined at search position k.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot_idx[gi]      = IW'((int'(ptr_eff) + gi) % N);
            assign grant_onehot[gi] = grant_valid && (grant_idx == IW'(gi));
        end
    endgenerate

    // First requester found along the rotated search order wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[rot_idx[i]]) begin
                grant_valid = 1'b1;
                grant_idx   = rot_idx[i];
            end
        end
    end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read master port between N requesters, one burst at a time.
// A granted burst owns the port from its AR handshake until the RLAST beat.
// Build macro AXI4_RD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins);
// the default build arbitrates round-robin.
module axi4_rd_arbiter
    import axi4_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req_arvalid,
    input  logic [N*AW-1:0]      req_araddr,
    input  logic [N*8-1:0]       req_arlen,
    input  logic [N*3-1:0]       req_arsize,
    input  logic [N*2-1:0]       req_arburst,
    output logic [N-1:0]         req_arready,
    output logic [N-1:0]         req_rvalid,
    output logic [DW-1:0]        req_rdata,
    output logic [1:0]           req_rresp,
    output logic                 req_rlast,
    input  logic [N-1:0]         req_rready,
    output logic                 m_arvalid,
    output logic [AW-1:0]        m_araddr,
    output logic [7:0]           m_arlen,
    output logic [2:0]           m_arsize,
    output logic [1:0]           m_arburst,
    input  logic                 m_arready,
    input  logic                 m_rvalid,
    input  logic [DW-1:0]        m_rdata,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rlast,
    output logic                 m_rready,
    output logic [$clog2(N)-1:0] grant,
    output logic                 busy,
    output logic                 len_err
);

    localparam int IW = $clog2(N);

    arb_state_e    state_reg, state_next;
    logic [IW-1:0] grant_reg;
    logic [IW-1:0] ptr_cur;
    logic [7:0]    cnt_reg;
    logic [AW-1:0] addr_reg;
    logic [7:0]    len_reg;
    logic [2:0]    size_reg;
    logic [1:0]    burst_reg;
    logic          busy_reg;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          ar_accept;
    logic          r_beat;

    logic [AW-1:0] addr_arr  [N];
    logic [7:0]    len_arr   [N];
    logic [2:0]    size_arr  [N];
    logic [1:0]    burst_arr [N];

    // Split the flattened per-requester AR buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_araddr[gi*AW +: AW];
            assign len_arr[gi]   = req_arlen[gi*8 +: 8];
            assign size_arr[gi]  = req_arsize[gi*3 +: 3];
            assign burst_arr[gi] = req_arburst[gi*2 +: 2];
        end
    endgenerate

    axi4_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req          (req_arvalid),
        .ptr          (ptr_cur),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .grant_valid  (pick_valid)
    );

`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
    assign ptr_cur = '0;
`else
    logic [IW-1:0] ptr_reg;
    assign ptr_cur = ptr_reg;

    // Round-robin pointer moves past the owner once its burst completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (state_reg == DATA && r_beat && m_rlast) begin
            ptr_reg <= IW'(rr_next(int'(grant_reg), N));
        end
    end
`endif

    // Next-state logic plus all handshake steering and the length check.
    always_comb begin
        state_next  = state_reg;
        ar_accept   = 1'b0;
        r_beat      = 1'b0;
        req_arready = '0;
        req_rvalid  = '0;
        req_rdata   = '0;
        req_rresp   = '0;
        req_rlast   = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        len_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Acceptance is suppressed while reset is held so no requester
                // sees an arready pulse for a grant that will be discarded.
                if (pick_valid && !reset) begin
                    ar_accept   = 1'b1;
                    req_arready = pick_onehot;
                    state_next  = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                m_rready              = req_rready[grant_reg];
                req_rvalid[grant_reg] = m_rvalid;
                req_rdata             = m_rdata;
                req_rresp             = m_rresp;
                req_rlast             = m_rlast;
                r_beat                = m_rvalid && req_rready[grant_reg];
                if (r_beat) begin
                    if (m_rlast) begin
                        state_next = IDLE;
                        len_err    = (cnt_reg != len_reg);
                    end else begin
                        len_err    = (cnt_reg == len_reg);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, owner, latched AR fields, beat counter and registered busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            len_reg   <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            if (ar_accept) begin
                grant_reg <= pick_idx;
                addr_reg  <= addr_arr[pick_idx];
                len_reg   <= len_arr[pick_idx];
                size_reg  <= size_arr[pick_idx];
                burst_reg <= burst_arr[pick_idx];
                cnt_reg   <= '0;
            end else if (r_beat) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign m_araddr  = addr_reg;
    assign m_arlen   = len_reg;
    assign m_arsize  = size_reg;
    assign m_arburst = burst_reg;
    assign grant     = grant_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench for axi4_rd_arbiter (N=2) with a queue/arithmetic reference model.
module tb_axi4_rd_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_arvalid;
    logic [N*AW-1:0]   req_araddr;
    logic [N*8-1:0]    req_arlen;
    logic [N*3-1:0]    req_arsize;
    logic [N*2-1:0]    req_arburst;
    logic [N-1:0]      req_arready;
    logic [N-1:0]      req_rvalid;
    logic [DW-1:0]     req_rdata;
    logic [1:0]        req_rresp;
    logic              req_rlast;
    logic [N-1:0]      req_rready;
    logic              m_arvalid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arready;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rready;
    logic [IW-1:0]     grant;
    logic              busy;
    logic              len_err;

    int checks = 0;
    int errors = 0;
    int mdl_ptr = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];

    always #5 clock = ~clock;

    axi4_rd_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_arvalid (req_arvalid),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arsize  (req_arsize),
        .req_arburst (req_arburst),
        .req_arready (req_arready),
        .req_rvalid  (req_rvalid),
        .req_rdata   (req_rdata),
        .req_rresp   (req_rresp),
        .req_rlast   (req_rlast),
        .req_rready  (req_rready),
        .m_arvalid   (m_arvalid),
        .m_araddr    (m_araddr),
        .m_arlen     (m_arlen),
        .m_arsize    (m_arsize),
        .m_arburst   (m_arburst),
        .m_arready   (m_arready),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rlast     (m_rlast),
        .m_rready    (m_rready),
        .grant       (grant),
        .busy        (busy),
        .len_err     (len_err)
    );

    // Reference model: first requester at or after the pointer, wrapping.
    function automatic int mdl_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int mdl_next(input int w);
`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
        return 0 * w;
`else
        return (w + 1) % N;
`endif
    endfunction

    function automatic int q_diff();
        int d = 0;
        if (obs_q.size() != exp_q.size()) return 1000;
        for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        req_araddr[i*AW +: AW] = a;
        req_arlen[i*8 +: 8]    = l;
        req_arsize[i*3 +: 3]   = s;
        req_arburst[i*2 +: 2]  = b;
    endtask

    // Observe the grant cycle and the AR phase; slave holds arready low for 'stall' cycles.
    task automatic ar_phase(input int stall, input bit keep, output int won, output logic arv_c0,
                            output logic [AW-1:0] a, output logic [7:0] l, output logic [2:0] s,
                            output logic [1:0] b, output logic busy_c1, output int unstable,
                            output logic onehot);
        logic [N-1:0] rdy;
        #1;
        rdy    = req_arready;
        arv_c0 = m_arvalid;
        onehot = $onehot(rdy);
        won    = -1;
        for (int i = 0; i < N; i++) if (rdy[i]) won = i;
        tick();
        if (!keep) req_arvalid = req_arvalid & ~rdy;
        #1;
        a = m_araddr; l = m_arlen; s = m_arsize; b = m_arburst; busy_c1 = busy;
        unstable = (m_arvalid !== 1'b1) ? 1 : 0;
        for (int c = 0; c < stall; c++) begin
            tick();
            #1;
            if (m_arvalid !== 1'b1 || m_araddr !== a || m_arlen !== l) unstable++;
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
    endtask

    // Slave R side: delivers exp_q beats with random gaps; records what the owner receives.
    task automatic r_phase(input int owner, input int nbeats, input int rlast_at, input bit toggle,
                           output int len_errs, output int route_bad, output int rready_bad,
                           output bit timeout);
        int bt = 0;
        int cyc = 0;
        len_errs = 0; route_bad = 0; rready_bad = 0; timeout = 1'b0;
        obs_q.delete();
        while (bt < nbeats && cyc < 300) begin
            m_rvalid   = ($urandom_range(0, 3) != 0);
            m_rdata    = exp_q[bt];
            m_rresp    = 2'b00;
            m_rlast    = (bt == rlast_at);
            req_rready = N'($urandom);
            req_rready[owner] = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (m_rready !== req_rready[owner]) rready_bad++;
            for (int i = 0; i < N; i++) begin
                if (i == owner) begin
                    if (req_rvalid[i] !== m_rvalid) route_bad++;
                end else if (req_rvalid[i] !== 1'b0) begin
                    route_bad++;
                end
            end
            if (len_err === 1'b1) len_errs++;
            if (req_rvalid[owner] === 1'b1 && req_rready[owner] === 1'b1) obs_q.push_back(req_rdata);
            if (m_rvalid && m_rready === 1'b1) bt++;
            cyc++;
            tick();
        end
        timeout    = (bt < nbeats);
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        req_rready = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0;
        req_arburst = '0; req_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        m_rresp = '0; m_rlast = 1'b0;
        tick(); tick();
        set_req(0, 32'h40, 8'd1, 3'd2, 2'b01);
        req_arvalid = 2'b01; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hdead_beef;
        #1;
        checks++;
        if ({m_arvalid, m_rready, req_arready, req_rvalid, req_rlast, busy, len_err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got arv=%b rrdy=%b arrdy=%b rvld=%b rlast=%b busy=%b lerr=%b, expected all 0",
                     m_arvalid, m_rready, req_arready, req_rvalid, req_rlast, busy, len_err);
        end
        checks++;
        if (req_rdata !== '0 || req_rresp !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%b, expected 0/0", req_rdata, req_rresp);
        end
        checks++;
        if (grant !== '0 || m_araddr !== '0 || m_arlen !== '0 || m_arsize !== '0 || m_arburst !== '0) begin
            errors++;
            $display("FAIL reset_regs: got grant=%0d addr=%h len=%0d, expected 0", grant, m_araddr, m_arlen);
        end
        $display("reset: checked outputs while reset held");
        req_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        tick();
        reset = 1'b0;
        mdl_ptr = 0;
    endtask

    task automatic test_single();
        int won, unst, le, rb, rrb; logic a0, bz, oh; bit to;
        logic [AW-1:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        set_req(0, 32'h100, 8'd3, 3'd2, 2'b01);
        req_arvalid = 2'b01;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back($urandom);
        ar_phase(0, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        checks++;
        if (won !== 0 || !oh) begin errors++; $display("FAIL single_arready: got winner %0d onehot=%b, expected 0", won, oh); end
        checks++;
        if (a0 !== 1'b0) begin errors++; $display("FAIL single_arvalid_c0: got %b, expected 0", a0); end
        checks++;
        if (a !== 32'h100 || l !== 8'd3 || bz !== 1'b1) begin
            errors++; $display("FAIL single_ar_fields: got addr=%h len=%0d busy=%b, expected 100/3/1", a, l, bz);
        end
        r_phase(0, 4, 3, 1'b0, le, rb, rrb, to);
        checks++;
        if (to || q_diff() != 0) begin errors++; $display("FAIL single_data: got %0d beats diff=%0d, expected 4 beats diff 0", obs_q.size(), q_diff()); end
        checks++;
        if (rb != 0 || rrb != 0 || le != 0) begin
            errors++; $display("FAIL single_route: got route_bad=%0d rready_bad=%0d len_err=%0d, expected 0", rb, rrb, le);
        end
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, expected 0", busy); end
        $display("single: req0 addr=%h len=%0d beats=%0d", a, l, obs_q.size());
        mdl_ptr = mdl_next(0);
    endtask

    task automatic test_round_robin();
        int won, unst, le, rb, rrb, w; logic a0, bz, oh; bit to;
        logic [AW-1:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        set_req(0, 32'h200, 8'd0, 3'd2, 2'b01);
        set_req(1, 32'h300, 8'd0, 3'd2, 2'b01);
        req_arvalid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            w = mdl_pick(2'b11, mdl_ptr);
            exp_q.delete();
            exp_q.push_back($urandom);
            ar_phase(0, 1'b1, won, a0, a, l, s, b, bz, unst, oh);
            checks++;
            if (won !== w || grant !== IW'(w)) begin
                errors++; $display("FAIL rr_grant: round %0d got winner %0d grant %0d, expected %0d", r, won, grant, w);
            end
            r_phase(w, 1, 0, 1'b0, le, rb, rrb, to);
            checks++;
            if (to || q_diff() != 0 || rb != 0) begin
                errors++; $display("FAIL rr_data: round %0d got diff=%0d route_bad=%0d, expected 0", r, q_diff(), rb);
            end
            $display("round_robin: round %0d grant %0d", r, won);
            mdl_ptr = mdl_next(w);
        end
        req_arvalid = '0;
    endtask

    task automatic test_ar_backpressure();
        int won, unst, le, rb, rrb, w; logic a0, bz, oh; bit to;
        logic [AW-1:0] a, ad; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        ad = $urandom & 32'hffff_fffc;
        set_req(1, ad, 8'd0, 3'd2, 2'b01);
        req_arvalid = 2'b10;
        w = mdl_pick(2'b10, mdl_ptr);
        exp_q.delete();
        exp_q.push_back($urandom);
        ar_phase(5, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        checks++;
        if (won !== w || a !== ad) begin errors++; $display("FAIL arbp_fields: got winner %0d addr %h, expected %0d %h", won, a, w, ad); end
        checks++;
        if (unst != 0) begin errors++; $display("FAIL arbp_stable: got %0d unstable cycles, expected 0", unst); end
        r_phase(w, 1, 0, 1'b0, le, rb, rrb, to);
        checks++;
        if (to || q_diff() != 0) begin errors++; $display("FAIL arbp_data: got diff=%0d, expected 0", q_diff()); end
        $display("ar_backpressure: addr=%h held 5 cycles", a);
        mdl_ptr = mdl_next(w);
    endtask

    task automatic test_r_backpressure();
        int won, unst, le, rb, rrb; logic a0, bz, oh; bit to;
        logic [AW-1:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        set_req(1, 32'h400, 8'd7, 3'd2, 2'b01);
        req_arvalid = 2'b10;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back($urandom);
        ar_phase(0, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        r_phase(1, 8, 7, 1'b1, le, rb, rrb, to);
        checks++;
        if (to || q_diff() != 0) begin errors++; $display("FAIL rbp_data: got %0d beats diff=%0d, expected 8 beats diff 0", obs_q.size(), q_diff()); end
        checks++;
        if (rrb != 0 || rb != 0) begin errors++; $display("FAIL rbp_route: got rready_bad=%0d route_bad=%0d, expected 0", rrb, rb); end
        checks++;
        if (le != 0) begin errors++; $display("FAIL rbp_len_err: got %0d pulses, expected 0", le); end
        $display("r_backpressure: %0d beats in order to req1", obs_q.size());
        mdl_ptr = mdl_next(1);
    endtask

    task automatic test_len_mismatch();
        int won, unst, le, rb, rrb; logic a0, bz, oh; bit to;
        logic [AW-1:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        set_req(0, 32'h500, 8'd3, 3'd2, 2'b01);
        req_arvalid = 2'b01;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back($urandom);
        ar_phase(0, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        r_phase(0, 3, 2, 1'b0, le, rb, rrb, to);
        checks++;
        if (to || le != 1) begin errors++; $display("FAIL lenerr_pulse: got %0d pulses, expected 1", le); end
        #1;
        checks++;
        if (busy !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL lenerr_idle: got busy=%b rready=%b, expected 0/0", busy, m_rready); end
        $display("len_mismatch: len=3 rlast on beat 2, len_err pulses=%0d", le);
        mdl_ptr = mdl_next(0);
    endtask

    task automatic test_random();
        int won, unst, le, rb, rrb, w, rl, exp_le; logic a0, bz, oh; bit to;
        logic [AW-1:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        logic [N-1:0] mask;
        logic [AW-1:0] ad [N]; logic [7:0] ln [N]; logic [2:0] sz [N]; logic [1:0] bu [N];
        for (int t = 0; t < 16; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                ad[i] = $urandom; ln[i] = 8'($urandom_range(0, 7));
                sz[i] = 3'($urandom_range(0, 2)); bu[i] = 2'($urandom_range(0, 2));
                set_req(i, ad[i], ln[i], sz[i], bu[i]);
            end
            req_arvalid = mask;
            w  = mdl_pick(mask, mdl_ptr);
            rl = int'(ln[w]);
            if ($urandom_range(0, 3) == 0) rl = $urandom_range(0, int'(ln[w]) + 2);
            exp_le = int'(rl != int'(ln[w])) + int'(rl > int'(ln[w]));
            exp_q.delete();
            for (int i = 0; i <= rl; i++) exp_q.push_back($urandom);
            ar_phase($urandom_range(0, 3), 1'b0, won, a0, a, l, s, b, bz, unst, oh);
            req_arvalid = '0;
            checks++;
            if (won !== w || grant !== IW'(w) || a !== ad[w] || l !== ln[w] || s !== sz[w] || b !== bu[w] || unst != 0) begin
                errors++;
                $display("FAIL rand_ar: txn %0d got winner %0d addr %h len %0d size %0d burst %0d, expected %0d %h %0d %0d %0d",
                         t, won, a, l, s, b, w, ad[w], ln[w], sz[w], bu[w]);
            end
            r_phase(w, rl + 1, rl, 1'($urandom_range(0, 1)), le, rb, rrb, to);
            checks++;
            if (to || q_diff() != 0 || rb != 0 || rrb != 0 || le != exp_le) begin
                errors++;
                $display("FAIL rand_r: txn %0d got diff=%0d route_bad=%0d rready_bad=%0d len_err=%0d, expected 0/0/0/%0d",
                         t, q_diff(), rb, rrb, le, exp_le);
            end
            $display("random: txn %0d mask=%b grant %0d len %0d rlast_at %0d len_err %0d", t, mask, won, l, rl, le);
            mdl_ptr = mdl_next(w);
        end
    endtask

    task automatic test_reset_mid();
        int won, unst, le, rb, rrb; logic a0, bz, oh; bit to;
        logic [AW-1:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b;
        // Complete one burst from req0 so a round-robin pointer would sit at 1.
        set_req(0, 32'h600, 8'd0, 3'd2, 2'b01);
        set_req(1, 32'h700, 8'd0, 3'd2, 2'b01);
        req_arvalid = 2'b01;
        exp_q.delete(); exp_q.push_back($urandom);
        ar_phase(0, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        r_phase(0, 1, 0, 1'b0, le, rb, rrb, to);
        // Start a 4-beat burst and reset after beat 1.
        set_req(0, 32'h800, 8'd3, 3'd2, 2'b01);
        req_arvalid = 2'b01;
        ar_phase(0, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        m_rvalid = 1'b1; m_rdata = $urandom; m_rlast = 1'b0; req_rready = 2'b01;
        tick(); tick();
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if ({m_arvalid, m_rready, req_arready, req_rvalid, req_rlast, busy, len_err} !== '0 || grant !== '0 || req_rdata !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got arv=%b rrdy=%b rvld=%b busy=%b grant=%0d rdata=%h, expected all 0",
                     m_arvalid, m_rready, req_rvalid, busy, grant, req_rdata);
        end
        reset = 1'b0; m_rvalid = 1'b0; req_rready = '0;
        mdl_ptr = 0;
        set_req(0, 32'h900, 8'd0, 3'd2, 2'b01);
        req_arvalid = 2'b11;
        exp_q.delete(); exp_q.push_back($urandom);
        ar_phase(0, 1'b0, won, a0, a, l, s, b, bz, unst, oh);
        req_arvalid = '0;
        checks++;
        if (won !== mdl_pick(2'b11, mdl_ptr) || a !== 32'h900) begin
            errors++; $display("FAIL midreset_ptr: got winner %0d addr %h, expected %0d 900", won, a, mdl_pick(2'b11, mdl_ptr));
        end
        r_phase(0, 1, 0, 1'b0, le, rb, rrb, to);
        checks++;
        if (to || q_diff() != 0) begin errors++; $display("FAIL midreset_data: got diff=%0d, expected 0", q_diff()); end
        $display("reset_mid: post-reset grant %0d", won);
        mdl_ptr = mdl_next(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ar_backpressure();
        test_r_backpressure();
        test_len_mismatch();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
